// File: rtl/coherence_memory_control_pkg.sv
// Shared types for the dual-core coherence memory controller: word, RAM handshake state, core count.
package coherence_memory_control_pkg;

  localparam int CPUS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/coherence_memory_control_rr_arbiter.sv
// Two-way round-robin arbiter; combinational grant, and the pointer moves to the other core on each taken grant.
module coherence_memory_control_rr_arbiter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic       o_vld,
  output logic       o_idx
);

  logic r_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_adv && o_vld) begin
      r_ptr <= ~o_idx;
    end
  end

  always_comb begin
    o_vld = |i_req;
    o_idx = (i_req == 2'b11) ? r_ptr : i_req[1];
  end

endmodule

// File: rtl/coherence_memory_control.sv
// Arbitrates both cores' fetch/read/write-back onto one RAM port and snoops the peer cache.
// Outputs are combinational from state; completion (wait low) is the RAM ACCESS cycle; BUSY/FREE/ERROR stall.
module coherence_memory_control
  import coherence_memory_control_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [CPUS-1:0]        i_iren,
  input  logic [CPUS-1:0]        i_dren,
  input  logic [CPUS-1:0]        i_dwen,
  input  word_t [CPUS-1:0]       i_iaddr,
  input  word_t [CPUS-1:0]       i_daddr,
  input  word_t [CPUS-1:0]       i_dstore,
  output word_t [CPUS-1:0]       o_iload,
  output word_t [CPUS-1:0]       o_dload,
  output logic [CPUS-1:0]        o_iwait,
  output logic [CPUS-1:0]        o_dwait,
  input  logic [CPUS-1:0]        i_cctrans,
  input  logic [CPUS-1:0]        i_ccwrite,
  input  logic [CPUS-1:0]        i_localwrit,
  input  logic [CPUS-1:0]        i_ccidrty,
  output logic [CPUS-1:0]        o_ccwait,
  output logic [CPUS-1:0]        o_ccinv,
  output word_t [CPUS-1:0]       o_ccsnoopaddr,
  output logic                   o_ramren,
  output logic                   o_ramwen,
  output word_t                  o_ramaddr,
  output word_t                  o_ramstore,
  input  word_t                  i_ramload,
  input  ramstate_t              i_ramstate
);

  typedef enum logic [2:0] {
    S_IDLE, S_IFETCH, S_SNOOP, S_DREAD, S_C2C, S_DWRITE, S_INVAL
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_gnt;
  logic       w_peer;
  logic       w_access;
  logic [1:0] w_dreq;
  logic       w_dvld;
  logic       w_didx;
  logic       w_ivld;
  logic       w_iidx;
  logic       w_idle;
  logic       w_unused_cctrans;

  assign w_unused_cctrans = |i_cctrans;
  assign w_peer   = ~r_gnt;
  assign w_access = (i_ramstate == ACCESS);
  assign w_idle   = (r_state == S_IDLE);

  // Upgrades, write-backs and reads share the data pointer; the highest pending class is the one arbitrated.
  assign w_dreq = (|i_localwrit) ? i_localwrit :
                  (|i_dwen)      ? i_dwen      : i_dren;

  coherence_memory_control_rr_arbiter u_data_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (w_dreq),
    .i_adv   (w_idle),
    .o_vld   (w_dvld),
    .o_idx   (w_didx)
  );

  coherence_memory_control_rr_arbiter u_inst_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_iren),
    .i_adv   (w_idle && !w_dvld),
    .o_vld   (w_ivld),
    .o_idx   (w_iidx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle) begin
        r_gnt <= w_dvld ? w_didx : w_iidx;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    o_iload       = '0;
    o_dload       = '0;
    o_iwait       = '1;
    o_dwait       = '1;
    o_ccwait      = '0;
    o_ccinv       = '0;
    o_ccsnoopaddr = '0;
    o_ramren      = 1'b0;
    o_ramwen      = 1'b0;
    o_ramaddr     = '0;
    o_ramstore    = '0;

    case (r_state)
      S_IDLE: begin
        if (|i_localwrit)  w_next = S_INVAL;
        else if (|i_dwen)  w_next = S_DWRITE;
        else if (|i_dren)  w_next = S_SNOOP;
        else if (w_ivld)   w_next = S_IFETCH;
      end

      S_IFETCH: begin
        if (!i_iren[r_gnt]) begin
          w_next = S_IDLE;
        end else begin
          o_ramren       = 1'b1;
          o_ramaddr      = i_iaddr[r_gnt];
          o_iload[r_gnt] = i_ramload;
          if (w_access) begin
            o_iwait[r_gnt] = 1'b0;
            w_next         = S_IDLE;
          end
        end
      end

      S_SNOOP: begin
        if (!i_dren[r_gnt]) begin
          w_next = S_IDLE;
        end else begin
          o_ccwait[w_peer]      = 1'b1;
          o_ccsnoopaddr[w_peer] = i_daddr[r_gnt];
          o_ccinv[w_peer]       = i_ccwrite[r_gnt];
          w_next                = i_ccidrty[w_peer] ? S_C2C : S_DREAD;
        end
      end

      S_DREAD: begin
        if (!i_dren[r_gnt]) begin
          w_next = S_IDLE;
        end else begin
          o_ccwait[w_peer]      = 1'b1;
          o_ccsnoopaddr[w_peer] = i_daddr[r_gnt];
          o_ramren              = 1'b1;
          o_ramaddr             = i_daddr[r_gnt];
          o_dload[r_gnt]        = i_ramload;
          if (w_access) begin
            o_dwait[r_gnt] = 1'b0;
            w_next         = S_IDLE;
          end
        end
      end

      // Peer's dirty line goes to the requester and is written back to RAM in the same handshake.
      S_C2C: begin
        if (!i_dren[r_gnt]) begin
          w_next = S_IDLE;
        end else begin
          o_ccwait[w_peer]      = 1'b1;
          o_ccsnoopaddr[w_peer] = i_daddr[r_gnt];
          o_dload[r_gnt]        = i_dstore[w_peer];
          o_ramwen              = 1'b1;
          o_ramaddr             = i_daddr[r_gnt];
          o_ramstore            = i_dstore[w_peer];
          if (w_access) begin
            o_dwait[r_gnt] = 1'b0;
            w_next         = S_IDLE;
          end
        end
      end

      S_DWRITE: begin
        if (!i_dwen[r_gnt]) begin
          w_next = S_IDLE;
        end else begin
          o_ramwen   = 1'b1;
          o_ramaddr  = i_daddr[r_gnt];
          o_ramstore = i_dstore[r_gnt];
          if (w_access) begin
            o_dwait[r_gnt] = 1'b0;
            w_next         = S_IDLE;
          end
        end
      end

      S_INVAL: begin
        o_ccinv[w_peer]       = 1'b1;
        o_ccsnoopaddr[w_peer] = i_daddr[r_gnt];
        o_dwait[r_gnt]        = 1'b0;
        w_next                = S_IDLE;
      end

      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_memory_control.sv
// Scoreboard bench: a RAM responder and a cache-side monitor run alongside the scenario tasks.
module tb_coherence_memory_control;
  import coherence_memory_control_pkg::*;

  localparam int K_I = 0;
  localparam int K_R = 1;
  localparam int K_W = 2;
  localparam int K_V = 3;

  typedef struct {
    int          kind;
    int          core;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      iren, dren, dwen, cctrans, ccwrite, localwrit, ccidrty;
  word_t [1:0]     iaddr, daddr, dstore;
  word_t [1:0]     iload, dload, ccsnoopaddr;
  logic [1:0]      iwait, dwait, ccwait, ccinv;
  logic            ramren, ramwen;
  word_t           ramaddr, ramstore, ramload;
  ramstate_t       ramstate;

  exp_t            sb[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              busy_n = 0;
  int              wb_left = 0;
  logic [31:0]     rdata = 32'h0;

  always #5 clk = ~clk;

  coherence_memory_control dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_iren        (iren),
    .i_dren        (dren),
    .i_dwen        (dwen),
    .i_iaddr       (iaddr),
    .i_daddr       (daddr),
    .i_dstore      (dstore),
    .o_iload       (iload),
    .o_dload       (dload),
    .o_iwait       (iwait),
    .o_dwait       (dwait),
    .i_cctrans     (cctrans),
    .i_ccwrite     (ccwrite),
    .i_localwrit   (localwrit),
    .i_ccidrty     (ccidrty),
    .o_ccwait      (ccwait),
    .o_ccinv       (ccinv),
    .o_ccsnoopaddr (ccsnoopaddr),
    .o_ramren      (ramren),
    .o_ramwen      (ramwen),
    .o_ramaddr     (ramaddr),
    .o_ramstore    (ramstore),
    .i_ramload     (ramload),
    .i_ramstate    (ramstate)
  );

  // RAM: busy_n BUSY cycles then ACCESS per strobe; read data is rdata XOR address.
  task automatic ram_model();
    int cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (ramren || ramwen) begin
        if (cnt < busy_n) begin
          ramstate = BUSY;
          cnt++;
        end else begin
          ramstate = ACCESS;
          cnt = 0;
        end
      end else begin
        ramstate = FREE;
        cnt = 0;
      end
      ramload = rdata ^ ramaddr;
    end
  endtask

  // Cache side: pops the scoreboard on every wait-low and withdraws the finished request.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (rst_n && (!iwait[c] || !dwait[c])) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done core=%0d iwait=%b dwait=%b", c, iwait, dwait);
          end else begin
            e = sb.pop_front();
            if (e.core != c || (e.kind == K_I) == iwait[c]) begin
              n_err++;
              $display("FAIL done_order core=%0d iwait=%b dwait=%b required kind=%0d core=%0d",
                       c, iwait, dwait, e.kind, e.core);
            end else begin
              case (e.kind)
                K_I: begin
                  if (iload[c] !== e.data || ramaddr !== e.addr || ramren !== 1'b1) begin
                    n_err++;
                    $display("FAIL ifetch core=%0d iload=%h addr=%h required iload=%h addr=%h",
                             c, iload[c], ramaddr, e.data, e.addr);
                  end
                  iren[c] = 1'b0;
                end
                K_R: begin
                  if (dload[c] !== e.data || ramaddr !== e.addr) begin
                    n_err++;
                    $display("FAIL dread core=%0d dload=%h addr=%h required dload=%h addr=%h",
                             c, dload[c], ramaddr, e.data, e.addr);
                  end
                  dren[c] = 1'b0;
                end
                K_W: begin
                  if (ramwen !== 1'b1 || ramren !== 1'b0 || ramstore !== e.data || ramaddr !== e.addr) begin
                    n_err++;
                    $display("FAIL dwrite core=%0d wen=%b store=%h addr=%h required store=%h addr=%h",
                             c, ramwen, ramstore, ramaddr, e.data, e.addr);
                  end
                  wb_left--;
                  if (wb_left <= 0) dwen[c] = 1'b0;
                end
                default: begin
                  if (ccinv[1-c] !== 1'b1 || ccsnoopaddr[1-c] !== e.addr || (ramren | ramwen) !== 1'b0) begin
                    n_err++;
                    $display("FAIL inval core=%0d ccinv=%b snoop=%h ren=%b wen=%b required snoop=%h",
                             c, ccinv, ccsnoopaddr[1-c], ramren, ramwen, e.addr);
                  end
                  localwrit[c] = 1'b0;
                end
              endcase
            end
          end
        end
      end
    end
  endtask

  task automatic wait_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic push(input int kind, input int core, input logic [31:0] data, input logic [31:0] addr);
    exp_t e;
    e.kind = kind; e.core = core; e.data = data; e.addr = addr;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iren = '0; dren = '0; dwen = '0; cctrans = '0; ccwrite = '0;
    localwrit = '0; ccidrty = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
    @(negedge clk);
    n_vec++;
    if (iwait !== 2'b11 || dwait !== 2'b11) begin
      n_err++; $display("FAIL reset_wait iwait=%b dwait=%b required 11/11", iwait, dwait);
    end
    n_vec++;
    if (ramren !== 1'b0 || ramwen !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
      n_err++; $display("FAIL reset_ram ren=%b wen=%b addr=%h store=%h required all 0", ramren, ramwen, ramaddr, ramstore);
    end
    n_vec++;
    if (ccwait !== 2'b00 || ccinv !== 2'b00 || iload !== '0 || dload !== '0 || ccsnoopaddr !== '0) begin
      n_err++; $display("FAIL reset_cc ccwait=%b ccinv=%b required 00/00 and zero loads", ccwait, ccinv);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_dual_fetch();
    bit ok;
    @(posedge clk); #1;
    busy_n = 2; rdata = 32'h00abcdef;
    iaddr[0] = 32'h0; iaddr[1] = 32'h200;
    push(K_I, 0, 32'h00abcdef, 32'h0);
    push(K_I, 1, 32'h00abcdef ^ 32'h200, 32'h200);
    iren = 2'b11;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (ramren !== 1'b1 || ramaddr !== 32'h0 || iwait !== 2'b11) begin
      n_err++; $display("FAIL fetch_busy ren=%b addr=%h iwait=%b required 1/0/11", ramren, ramaddr, iwait);
    end
    wait_empty(40, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL fetch_timeout pending=%0d required 0", sb.size()); end
  endtask

  task automatic test_data_read();
    bit ok;
    @(posedge clk); #1;
    busy_n = 1; rdata = 32'h00fedcba;
    daddr[0] = 32'h40; iaddr[0] = 32'h300;
    push(K_R, 0, 32'h00fedcba ^ 32'h40, 32'h40);
    push(K_I, 0, 32'h00fedcba ^ 32'h300, 32'h300);
    iren = 2'b01; dren = 2'b01;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (ccwait !== 2'b10 || ccsnoopaddr[1] !== 32'h40 || ccinv !== 2'b00 || ramren !== 1'b0) begin
      n_err++; $display("FAIL snoop ccwait=%b snoop=%h ccinv=%b ren=%b required 10/40/00/0",
                        ccwait, ccsnoopaddr[1], ccinv, ramren);
    end
    wait_empty(40, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL dread_timeout pending=%0d required 0", sb.size()); end
  endtask

  task automatic test_c2c();
    bit ok;
    @(posedge clk); #1;
    busy_n = 1; rdata = 32'h0;
    dstore[0] = 32'h5555aaaa; dstore[1] = 32'h12345678;
    daddr[0] = 32'h80; ccidrty = 2'b11;
    push(K_R, 0, 32'h12345678, 32'h80);
    dren = 2'b01;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (ramwen !== 1'b1 || ramren !== 1'b0 || ramstore !== 32'h12345678 ||
        dload[0] !== 32'h12345678 || dwait !== 2'b11 || ccwait !== 2'b10) begin
      n_err++; $display("FAIL c2c_busy wen=%b ren=%b store=%h dload=%h dwait=%b required 1/0/12345678/12345678/11",
                        ramwen, ramren, ramstore, dload[0], dwait);
    end
    wait_empty(40, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL c2c_timeout pending=%0d required 0", sb.size()); end
    ccidrty = 2'b00;
  endtask

  task automatic test_back_to_back_writeback();
    bit ok;
    @(posedge clk); #1;
    busy_n = 1; wb_left = 2;
    dstore[0] = 32'hdeadbeef; daddr[0] = 32'hc0;
    push(K_W, 0, 32'hdeadbeef, 32'hc0);
    push(K_W, 0, 32'hdeadbeef, 32'hc0);
    dwen = 2'b01;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (ramwen !== 1'b1 || ramren !== 1'b0 || dwait !== 2'b11) begin
      n_err++; $display("FAIL wb_busy wen=%b ren=%b dwait=%b required 1/0/11", ramwen, ramren, dwait);
    end
    wait_empty(40, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL wb_timeout pending=%0d required 0", sb.size()); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_inval();
    bit ok;
    @(posedge clk); #1;
    daddr[1] = 32'h100;
    push(K_V, 1, 32'h0, 32'h100);
    localwrit = 2'b10;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (ccinv !== 2'b01 || dwait !== 2'b01 || ccwait !== 2'b00) begin
      n_err++; $display("FAIL inval_cycle ccinv=%b dwait=%b ccwait=%b required 01/01/00", ccinv, dwait, ccwait);
    end
    @(negedge clk);
    n_vec++;
    if (ccinv !== 2'b00 || dwait !== 2'b11) begin
      n_err++; $display("FAIL inval_one_cycle ccinv=%b dwait=%b required 00/11", ccinv, dwait);
    end
    wait_empty(10, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL inval_timeout pending=%0d required 0", sb.size()); end
  endtask

  task automatic test_reset_mid_dread();
    @(posedge clk); #1;
    busy_n = 5; rdata = 32'h0;
    daddr[1] = 32'h140;
    dren = 2'b10;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (ramren !== 1'b1 || ramaddr !== 32'h140 || ccwait !== 2'b01) begin
      n_err++; $display("FAIL dread_active ren=%b addr=%h ccwait=%b required 1/140/01", ramren, ramaddr, ccwait);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ramren !== 1'b0 || ramwen !== 1'b0 || ramaddr !== 32'h0 || ccwait !== 2'b00 ||
        dwait !== 2'b11 || iwait !== 2'b11 || dload !== '0 || ccsnoopaddr !== '0) begin
      n_err++; $display("FAIL abort_reset ren=%b wen=%b addr=%h ccwait=%b dwait=%b required reset values",
                        ramren, ramwen, ramaddr, ccwait, dwait);
    end
    dren = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (ramren !== 1'b0 || dwait !== 2'b11) begin
      n_err++; $display("FAIL post_reset_idle ren=%b dwait=%b required 0/11", ramren, dwait);
    end
  endtask

  initial begin
    test_reset();
    fork
      ram_model();
      monitor();
    join_none
    test_dual_fetch();
    test_data_read();
    test_c2c();
    test_back_to_back_writeback();
    test_inval();
    test_reset_mid_dread();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_left pending=%0d required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
